// File: rtl/count_display_scanner.sv
// count_display_scanner
// Brings the asynchronous 4-bit count into the clk domain and filters it.
// Splits the count into tens/ones and scans a 4-digit common-anode display
// (active-low anodes and segments), blanking all anodes for the first
// BLANK_CYCLES clocks of every digit slot to suppress ghosting.
// The decimal point on the ones digit flags a freshly loaded value for one frame.
// Optional build macro: BLANK_LEADING_ZERO_EN blanks the tens digit when it is zero.
module count_display_scanner #(
   parameter int CLK_HZ       = 100000000,
   parameter int REFRESH_HZ   = 1000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic       clk,
   input  logic       Clear_n,
   input  logic [3:0] value,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       frame_tick,
   output logic [3:0] disp_val
);

   localparam int SLOT   = CLK_HZ / (REFRESH_HZ * 4);
   localparam int FRAME  = SLOT * 4;
   localparam int CNT_W  = (SLOT > 1) ? $clog2(SLOT) : 1;
   localparam int HOLD_W = $clog2(FRAME + 1);

   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SLOT - 1);
   localparam logic [CNT_W-1:0]  BLANK_END = CNT_W'(BLANK_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(FRAME);

   // A slot must contain at least one active clock after the blanking window.
   generate
      if (SLOT <= BLANK_CYCLES) begin : g_cfg_check
         $error("count_display_scanner: SLOT must be greater than BLANK_CYCLES");
      end
   endgenerate

   typedef enum logic [1:0] {
      SLOT0 = 2'd0,
      SLOT1 = 2'd1,
      SLOT2 = 2'd2,
      SLOT3 = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [3:0]         s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
   logic [3:0]         disp_val_q, disp_val_d;
   logic [HOLD_W-1:0]  hold_q, hold_d;
   logic [3:0]         an_q, an_d;
   logic [6:0]         seg_q, seg_d;
   logic               dp_q, dp_d;
   logic               frame_tick_q, frame_tick_d;
   logic               load_new_s;
   logic               tens_s;
   logic [3:0]         ones_s;

   // Active-low gfedcba pattern for one decimal digit; anything else is dark.
   function automatic logic [6:0] seg_decode(input logic [3:0] digit);
      logic [6:0] pat;
      case (digit)
         4'd0:    pat = 7'b1000000;
         4'd1:    pat = 7'b1111001;
         4'd2:    pat = 7'b0100100;
         4'd3:    pat = 7'b0110000;
         4'd4:    pat = 7'b0011001;
         4'd5:    pat = 7'b0010010;
         4'd6:    pat = 7'b0000010;
         4'd7:    pat = 7'b1111000;
         4'd8:    pat = 7'b0000000;
         4'd9:    pat = 7'b0010000;
         default: pat = 7'b1111111;
      endcase
      return pat;
   endfunction

   // Input synchroniser, stability filter, update-indicator hold and digit split.
   always_comb begin
      s1_d       = value;
      s2_d       = s1_q;
      s3_d       = s2_q;
      disp_val_d = disp_val_q;
      load_new_s = 1'b0;
      if (s2_q == s3_q) begin
         disp_val_d = s2_q;
         load_new_s = (s2_q != disp_val_q);
      end else begin
         disp_val_d = disp_val_q;
      end
      if (load_new_s) begin
         hold_d = HOLD_INIT;
      end else if (hold_q != '0) begin
         hold_d = hold_q - HOLD_W'(1);
      end else begin
         hold_d = '0;
      end
      tens_s = (disp_val_q >= 4'd10);
      if (tens_s) begin
         ones_s = disp_val_q - 4'd10;
      end else begin
         ones_s = disp_val_q;
      end
   end

   // Scan FSM next state: slot counter wraps at SLOT-1 and advances the digit index.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
         case (state_q)
            SLOT0:   state_d = SLOT1;
            SLOT1:   state_d = SLOT2;
            SLOT2:   state_d = SLOT3;
            SLOT3:   state_d = SLOT0;
            default: state_d = SLOT0;
         endcase
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Next display outputs from the current slot position and displayed value.
   always_comb begin
      an_d         = 4'b1111;
      seg_d        = 7'b1111111;
      dp_d         = 1'b1;
      frame_tick_d = (state_q == SLOT3) && (cnt_q == CNT_LAST);
      if (cnt_q >= BLANK_END) begin
         case (state_q)
            SLOT0: begin
               an_d  = 4'b1110;
               seg_d = seg_decode(ones_s);
               dp_d  = (hold_q == '0);
            end
            SLOT1: begin
               an_d = 4'b1101;
`ifdef BLANK_LEADING_ZERO_EN
               if (tens_s) begin
                  seg_d = seg_decode(4'd1);
               end else begin
                  seg_d = 7'b1111111;
               end
`else
               seg_d = seg_decode({3'b000, tens_s});
`endif
            end
            default: begin
               an_d  = 4'b1111;
               seg_d = 7'b1111111;
            end
         endcase
      end else begin
         an_d  = 4'b1111;
         seg_d = 7'b1111111;
      end
   end

   // Scan FSM state register and slot counter.
   always_ff @(posedge clk or negedge Clear_n) begin
      if (!Clear_n) begin
         state_q <= SLOT0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Synchroniser stages, displayed value, hold timer and registered outputs.
   always_ff @(posedge clk or negedge Clear_n) begin
      if (!Clear_n) begin
         s1_q         <= 4'd0;
         s2_q         <= 4'd0;
         s3_q         <= 4'd0;
         disp_val_q   <= 4'd0;
         hold_q       <= '0;
         an_q         <= 4'b1111;
         seg_q        <= 7'b1111111;
         dp_q         <= 1'b1;
         frame_tick_q <= 1'b0;
      end else begin
         s1_q         <= s1_d;
         s2_q         <= s2_d;
         s3_q         <= s3_d;
         disp_val_q   <= disp_val_d;
         hold_q       <= hold_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign an         = an_q;
   assign seg        = seg_q;
   assign dp         = dp_q;
   assign frame_tick = frame_tick_q;
   assign disp_val   = disp_val_q;

endmodule

// File: tb/tb_count_display_scanner.sv
// Scoreboard bench for count_display_scanner with SLOT=4 (16-clk frame).
// Stimulus pushes time-stamped expectations; a monitor compares them after each edge.
module tb_count_display_scanner;

   logic       clk;
   logic       Clear_n;
   logic [3:0] value;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;
   logic       frame_tick;
   logic [3:0] disp_val;

   count_display_scanner #(
      .CLK_HZ      (16),
      .REFRESH_HZ  (1),
      .BLANK_CYCLES(1)
   ) dut (
      .clk       (clk),
      .Clear_n   (Clear_n),
      .value     (value),
      .an        (an),
      .seg       (seg),
      .dp        (dp),
      .frame_tick(frame_tick),
      .disp_val  (disp_val)
   );

`ifdef BLANK_LEADING_ZERO_EN
   localparam logic [6:0] LZ_SEG = 7'b1111111;
`else
   localparam logic [6:0] LZ_SEG = 7'b1000000;
`endif

   localparam logic [4:0] M_AN  = 5'b10000;
   localparam logic [4:0] M_SEG = 5'b01000;
   localparam logic [4:0] M_DP  = 5'b00100;
   localparam logic [4:0] M_FT  = 5'b00010;
   localparam logic [4:0] M_DV  = 5'b00001;

   typedef struct {
      int         cyc;
      string      name;
      logic [4:0] m;
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       ft;
      logic [3:0] dv;
   } exp_t;

   exp_t exp_q[$];
   int   cyc      = 0;
   int   base     = 0;
   int   checks   = 0;
   int   failures = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic push_exp(input int k, input string name, input logic [4:0] m,
                           input logic [3:0] e_an, input logic [6:0] e_seg,
                           input logic e_dp, input logic e_ft, input logic [3:0] e_dv);
      exp_t e;
      e.cyc  = base + k;
      e.name = name;
      e.m    = m;
      e.an   = e_an;
      e.seg  = e_seg;
      e.dp   = e_dp;
      e.ft   = e_ft;
      e.dv   = e_dv;
      exp_q.push_back(e);
   endtask

   // Return at the falling edge following edge k (relative to base).
   task automatic wait_k(input int k);
      while (cyc < base + k) @(negedge clk);
   endtask

   task automatic chk(input string nm, input logic [6:0] got, input logic [6:0] expv);
      checks++;
      if (got !== expv) begin
         failures++;
         $display("FAIL %s: got %b expected %b (cycle %0d)", nm, got, expv, cyc);
      end
   endtask

   // Monitor: after every rising edge, compare all expectations due now.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         cyc++;
         #2;
         while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            if (e.cyc < cyc) begin
               checks++;
               failures++;
               $display("FAIL %s: missed, due cycle %0d seen at %0d", e.name, e.cyc, cyc);
            end else begin
               if (e.m[4]) chk({e.name, ".an"},  {3'b000, an},         {3'b000, e.an});
               if (e.m[3]) chk({e.name, ".seg"}, seg,                  e.seg);
               if (e.m[2]) chk({e.name, ".dp"},  {6'b000000, dp},      {6'b000000, e.dp});
               if (e.m[1]) chk({e.name, ".ft"},  {6'b000000, frame_tick}, {6'b000000, e.ft});
               if (e.m[0]) chk({e.name, ".dv"},  {3'b000, disp_val},   {3'b000, e.dv});
            end
         end
      end
   end

   // Watchdog: a stalled run still reports.
   initial begin
      #100000;
      failures++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Directed stimulus with hand-computed expectations.
   initial begin
      exp_t e;
      Clear_n = 1'b0;
      value   = 4'd0;
      base    = 0;

      // 1: reset held 3 clks, then one blank clk and digit 0 on idx0
      for (int k = 1; k <= 3; k++)
         push_exp(k, "t1_rst", M_AN | M_SEG | M_DP | M_FT | M_DV,
                  4'b1111, 7'b1111111, 1'b1, 1'b0, 4'd0);
      wait_k(3);
      Clear_n = 1'b1;
      base    = cyc;
      push_exp(1, "t1_blank", M_AN | M_SEG | M_FT, 4'b1111, 7'b1111111, 1'b1, 1'b0, 4'd0);
      push_exp(2, "t1_idx0", M_AN | M_SEG | M_DP | M_DV, 4'b1110, 7'b1000000, 1'b1, 1'b0, 4'd0);

      // 2: value 14 -> disp_val on 4th edge; 4 on idx0, 1 on idx1; dp for one frame
      wait_k(2);
      value = 4'd14;
      push_exp(5,  "t2_dv_pre",   M_DV, 4'b1111, 7'b1111111, 1'b1, 1'b0, 4'd0);
      push_exp(6,  "t2_dv",       M_DV, 4'b1111, 7'b1111111, 1'b1, 1'b0, 4'd14);
      push_exp(7,  "t2_idx1",     M_AN | M_SEG, 4'b1101, 7'b1111001, 1'b1, 1'b0, 4'd14);
      push_exp(16, "t2_ft",       M_AN | M_FT, 4'b1111, 7'b1111111, 1'b1, 1'b1, 4'd14);
      push_exp(17, "t2_ft_off",   M_AN | M_SEG | M_FT, 4'b1111, 7'b1111111, 1'b1, 1'b0, 4'd14);
      push_exp(18, "t2_idx0_dp",  M_AN | M_SEG | M_DP, 4'b1110, 7'b0011001, 1'b0, 1'b0, 4'd14);
      push_exp(20, "t2_idx0_dp2", M_AN | M_SEG | M_DP, 4'b1110, 7'b0011001, 1'b0, 1'b0, 4'd14);
      push_exp(23, "t2_idx1_b",   M_AN | M_SEG | M_DP, 4'b1101, 7'b1111001, 1'b1, 1'b0, 4'd14);
      push_exp(34, "t2_dp_off",   M_AN | M_SEG | M_DP, 4'b1110, 7'b0011001, 1'b1, 1'b0, 4'd14);

      // 3: value 2, later a 1-clk glitch to 6 that must be filtered
      wait_k(36);
      value = 4'd2;
      push_exp(39, "t3_dv_old", M_DV, 4'b1111, 7'b1111111, 1'b1, 1'b0, 4'd14);
      push_exp(40, "t3_dv",     M_DV, 4'b1111, 7'b1111111, 1'b1, 1'b0, 4'd2);
      push_exp(50, "t3_dp_on",  M_AN | M_SEG | M_DP, 4'b1110, 7'b0100100, 1'b0, 1'b0, 4'd2);
      wait_k(60);
      value = 4'd6;
      for (int k = 62; k <= 66; k++)
         push_exp(k, "t3_glitch_dv", M_DV, 4'b1111, 7'b1111111, 1'b1, 1'b0, 4'd2);
      push_exp(66, "t3_idx0",   M_AN | M_SEG | M_DP, 4'b1110, 7'b0100100, 1'b1, 1'b0, 4'd2);
      push_exp(71, "t3_idx1",   M_AN | M_SEG | M_DP, 4'b1101, LZ_SEG, 1'b1, 1'b0, 4'd2);
      wait_k(61);
      value = 4'd2;

      // 4: value 7 -> 7 on idx0, leading zero handling on idx1
      wait_k(72);
      value = 4'd7;
      push_exp(75, "t4_dv_pre", M_DV, 4'b1111, 7'b1111111, 1'b1, 1'b0, 4'd2);
      push_exp(76, "t4_dv",     M_DV, 4'b1111, 7'b1111111, 1'b1, 1'b0, 4'd7);
      push_exp(82, "t4_idx0",   M_AN | M_SEG | M_DP, 4'b1110, 7'b1111000, 1'b0, 1'b0, 4'd7);
      push_exp(87, "t4_idx1",   M_AN | M_SEG | M_DP, 4'b1101, LZ_SEG, 1'b1, 1'b0, 4'd7);

      // 6: free run 64 clks: frame_tick every 16, idx2/idx3 always dark
      wait_k(90);
      for (int k = 97; k <= 160; k++) begin
         int         p;
         int         sl;
         int         ps;
         logic [3:0] ea;
         p  = (k - 1) % 16;
         sl = p / 4;
         ps = p % 4;
         if (ps == 0)      ea = 4'b1111;
         else if (sl == 0) ea = 4'b1110;
         else if (sl == 1) ea = 4'b1101;
         else              ea = 4'b1111;
         push_exp(k, "t6_scan", M_AN | M_FT | M_DP, ea, 7'b1111111, 1'b1, (p == 15), 4'd7);
      end

      // 5: asynchronous clear during idx1 active part, then restart and re-sync
      wait_k(165);
      push_exp(166, "t5_async", M_AN | M_SEG | M_DP | M_DV, 4'b1111, 7'b1111111, 1'b1, 1'b0, 4'd0);
      @(posedge clk);
      #1;
      Clear_n = 1'b0;
      @(negedge clk);
      Clear_n = 1'b1;
      base    = cyc;
      push_exp(1, "t5_blank", M_AN | M_SEG | M_FT, 4'b1111, 7'b1111111, 1'b1, 1'b0, 4'd0);
      push_exp(2, "t5_idx0",  M_AN | M_SEG | M_DV, 4'b1110, 7'b1000000, 1'b1, 1'b0, 4'd0);
      push_exp(3, "t5_dv_pre", M_DV, 4'b1111, 7'b1111111, 1'b1, 1'b0, 4'd0);
      push_exp(4, "t5_dv",     M_DV, 4'b1111, 7'b1111111, 1'b1, 1'b0, 4'd7);
      wait_k(10);

      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         failures++;
         $display("FAIL %s: got unchecked expected checked by cycle %0d", e.name, e.cyc);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
